// File: rtl/tt_sweep_pkg.sv
// Shared types and sizes for the truth-table sweep controller.
package tt_sweep_pkg;

  localparam int N_IN  = 4;
  localparam int N_OUT = 4;
  localparam int N_VEC = 16;
  localparam int ERR_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    CAPTURE,
    DONE
  } state_t;

endpackage

// File: rtl/tt_expect_table.sv
// Expected-response table: 16 x 4 register file, synchronous write,
// combinational read, synchronous active-low clear.
module tt_expect_table
  import tt_sweep_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [N_IN-1:0]  waddr,
  input  logic [N_OUT-1:0] wdata,
  input  logic [N_IN-1:0]  raddr,
  output logic [N_OUT-1:0] rdata
);

  logic [N_OUT-1:0] mem [N_VEC];

  // Clear every entry on reset, otherwise write the addressed entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_VEC; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep controller: drives all 16 input combinations into a
// 4-in/4-out logic block, waits a settle time, captures the response and
// compares it with a programmable expected table.
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_addr,
  input  logic [3:0]       cfg_data,
  output logic [3:0]       dut_in,
  input  logic [3:0]       dut_out,
  output logic             busy,
  output logic             res_valid,
  output logic [3:0]       res_idx,
  output logic [3:0]       res_data,
  output logic             res_err,
  output logic             done,
  output logic             aborted,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       first_err_idx
);

  localparam logic [7:0]       CNT_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0]  LAST_IDX = N_IN'(N_VEC - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = ERR_W'(N_VEC);

  state_t           state;
  logic [N_IN-1:0]  idx;
  logic [7:0]       cnt;
  logic [N_OUT-1:0] exp_data;
  logic             mismatch;

  tt_expect_table u_table (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (cfg_we && (state == IDLE)),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (idx),
    .rdata (exp_data)
  );

  assign mismatch = (dut_out != exp_data);

  // Sweep sequencing with registered outputs; dut_in is loaded on entry to
  // APPLY so it is stable for the whole APPLY/SETTLE/CAPTURE window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      cnt           <= '0;
      dut_in        <= '0;
      busy          <= 1'b0;
      res_valid     <= 1'b0;
      res_idx       <= '0;
      res_data      <= '0;
      res_err       <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
    end else begin
      res_valid <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      if ((state != IDLE) && abort) begin
        state   <= IDLE;
        busy    <= 1'b0;
        dut_in  <= '0;
        aborted <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              state         <= APPLY;
              busy          <= 1'b1;
              idx           <= '0;
              dut_in        <= '0;
              err_count     <= '0;
              first_err_idx <= '0;
              pass          <= 1'b0;
            end
          end
          APPLY: begin
            cnt   <= CNT_LOAD;
            state <= SETTLE;
          end
          SETTLE: begin
            if (cnt == '0) state <= CAPTURE;
            else           cnt   <= cnt - 8'd1;
          end
          CAPTURE: begin
            res_valid <= 1'b1;
            res_idx   <= idx;
            res_data  <= dut_out;
            res_err   <= mismatch;
            if (mismatch) begin
              if (err_count != ERR_MAX) err_count <= err_count + 5'd1;
              if (err_count == '0)      first_err_idx <= idx;
            end
            if (idx == LAST_IDX) begin
              state  <= DONE;
              dut_in <= '0;
            end else begin
              idx    <= idx + 4'd1;
              dut_in <= idx + 4'd1;
              state  <= APPLY;
            end
          end
          DONE: begin
            done  <= 1'b1;
            pass  <= (err_count == '0);
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Self-checking bench for tt_sweep_ctrl: table-driven directed sweeps,
// hand-written abort/reset/busy sequences and randomized sweeps, all checked
// against timing and results computed from the sweep rules.
module tb_tt_sweep_ctrl;

  localparam int S = 4;
  localparam int P = S + 2;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, cfg_we;
  logic [3:0] cfg_addr, cfg_data;
  logic [3:0] dut_in, dut_out;
  logic       busy, res_valid, res_err, done, aborted, pass;
  logic [3:0] res_idx, res_data, first_err_idx;
  logic [4:0] err_count;

  logic [3:0] tbl  [16];
  logic [3:0] resp [16];

  int n_checks = 0;
  int n_errs   = 0;

  typedef struct {
    int tkind;
    int rkind;
    int ex_err;
    int ex_first;
    bit ex_pass;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  // Logic block under test: looked up from the bench's response array
  assign dut_out = resp[dut_in];

  tt_sweep_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .dut_in(dut_in), .dut_out(dut_out), .busy(busy),
    .res_valid(res_valid), .res_idx(res_idx), .res_data(res_data),
    .res_err(res_err), .done(done), .aborted(aborted), .pass(pass),
    .err_count(err_count), .first_err_idx(first_err_idx)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s @%0d: got %0d expected %0d", nm, c, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".dut_in"}, 0, 32'(dut_in), 0);
    chk({nm, ".busy"}, 0, 32'(busy), 0);
    chk({nm, ".res_valid"}, 0, 32'(res_valid), 0);
    chk({nm, ".res_idx"}, 0, 32'(res_idx), 0);
    chk({nm, ".res_data"}, 0, 32'(res_data), 0);
    chk({nm, ".res_err"}, 0, 32'(res_err), 0);
    chk({nm, ".done"}, 0, 32'(done), 0);
    chk({nm, ".aborted"}, 0, 32'(aborted), 0);
    chk({nm, ".pass"}, 0, 32'(pass), 0);
    chk({nm, ".err_count"}, 0, 32'(err_count), 0);
    chk({nm, ".first_err_idx"}, 0, 32'(first_err_idx), 0);
  endtask

  task automatic write_tbl(input int a, input logic [3:0] d);
    cfg_we = 1'b1; cfg_addr = 4'(a); cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic setup(input int tk, input int rk);
    for (int i = 0; i < 16; i++) begin
      logic [3:0] iv;
      iv = 4'(i);
      case (tk)
        0: tbl[i] = ~iv;
        1: tbl[i] = (i == 5) ? 4'h0 : ~iv;
        default: tbl[i] = 4'h0;
      endcase
      case (rk)
        0: resp[i] = ~iv;
        1: resp[i] = 4'h0;
        default: resp[i] = iv;
      endcase
    end
    for (int i = 0; i < 16; i++) write_tbl(i, tbl[i]);
  endtask

  // Expected summary of a sweep from the bench's table and response arrays
  task automatic model(output int e, output int f, output bit p);
    e = 0; f = 0;
    for (int i = 0; i < 16; i++)
      if (resp[i] != tbl[i]) begin
        if (e == 0) f = i;
        e++;
      end
    p = (e == 0);
  endtask

  // Full sweep from start; optionally pokes start + cfg_we while busy
  task automatic run_sweep(input bit inj, input int ex_err, input int ex_first, input bit ex_pass);
    start = 1'b1;
    tick();
    for (int c = 0; c <= 16 * P + 2; c++) begin
      if (c > 0) tick();
      start  = 1'b0;
      cfg_we = 1'b0;
      chk("busy", c, 32'(busy), 32'(c <= 16 * P));
      chk("done", c, 32'(done), 32'(c == 16 * P + 1));
      chk("aborted", c, 32'(aborted), 0);
      if (c < 16 * P) chk("dut_in", c, 32'(dut_in), 32'(c / P));
      if (c >= P && c <= 16 * P && (c % P) == 0) begin
        int i;
        i = c / P - 1;
        chk("res_valid", c, 32'(res_valid), 1);
        chk("res_idx", c, 32'(res_idx), 32'(i));
        chk("res_data", c, 32'(res_data), 32'(resp[i]));
        chk("res_err", c, 32'(res_err), 32'(resp[i] != tbl[i]));
      end else begin
        chk("res_valid", c, 32'(res_valid), 0);
      end
      if (c == 16 * P + 1) begin
        chk("pass", c, 32'(pass), 32'(ex_pass));
        chk("err_count", c, 32'(err_count), 32'(ex_err));
        chk("first_err_idx", c, 32'(first_err_idx), 32'(ex_first));
      end
      if (inj && c == 20) begin
        start = 1'b1; cfg_we = 1'b1; cfg_addr = 4'd3; cfg_data = ~tbl[3];
      end
    end
  endtask

  initial begin
    int e, f;
    bit p;
    vecs[0] = '{0, 0, 0, 0, 1};
    vecs[1] = '{1, 0, 1, 5, 0};
    vecs[2] = '{0, 1, 15, 0, 0};
    vecs[3] = '{0, 2, 16, 0, 0};
    vecs[4] = '{2, 1, 0, 0, 1};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_we = 1'b0;
    cfg_addr = '0; cfg_data = '0;
    for (int i = 0; i < 16; i++) resp[i] = 4'hA;
    tick(); tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) begin
      setup(vecs[v].tkind, vecs[v].rkind);
      run_sweep(1'b0, vecs[v].ex_err, vecs[v].ex_first, vecs[v].ex_pass);
    end

    // start and table write while busy are dropped
    setup(0, 0);
    run_sweep(1'b1, 0, 0, 1);

    // table write on the start cycle lands before the sweep reads it
    tbl[9] = 4'h9;
    cfg_we = 1'b1; cfg_addr = 4'd9; cfg_data = 4'h9;
    run_sweep(1'b0, 1, 9, 0);

    // abort (with a simultaneous start) during SETTLE of idx 7
    setup(0, 0);
    resp[2] = 4'h0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 44; c++) tick();
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort.busy", 45, 32'(busy), 0);
    chk("abort.aborted", 45, 32'(aborted), 1);
    chk("abort.dut_in", 45, 32'(dut_in), 0);
    chk("abort.done", 45, 32'(done), 0);
    chk("abort.err_count", 45, 32'(err_count), 1);
    chk("abort.first_err_idx", 45, 32'(first_err_idx), 2);
    for (int c = 46; c < 52; c++) begin
      tick();
      chk("abort.aborted_pulse", c, 32'(aborted), 0);
      chk("abort.idle_busy", c, 32'(busy), 0);
      chk("abort.idle_done", c, 32'(done), 0);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort.aborted", 0, 32'(aborted), 0);
    chk("idle_abort.busy", 0, 32'(busy), 0);
    resp[2] = ~4'h2;
    run_sweep(1'b0, 0, 0, 1);

    // reset at idx 10 abandons the sweep and clears the table
    setup(0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 62; c++) tick();
    chk("pre_reset.dut_in", 62, 32'(dut_in), 10);
    rst_n = 1'b0;
    tick();
    chk_zero("midreset");
    rst_n = 1'b1;
    for (int c = 0; c < 110; c++) begin
      tick();
      if (done !== 1'b0 || aborted !== 1'b0 || busy !== 1'b0) begin
        chk("midreset.quiet", c, 32'({busy, done, aborted}), 0);
        break;
      end
    end
    chk("midreset.final_quiet", 0, 32'({busy, done, aborted}), 0);
    for (int i = 0; i < 16; i++) begin
      tbl[i] = 4'h0;
      resp[i] = 4'h0;
    end
    run_sweep(1'b0, 0, 0, 1);

    // randomized tables and responses
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) begin
        tbl[i] = 4'($urandom);
        resp[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : tbl[i];
      end
      for (int i = 0; i < 16; i++) write_tbl(i, tbl[i]);
      model(e, f, p);
      run_sweep(1'b0, e, f, p);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/tt_sweep_ctrl.md
TT_SWEEP_CTRL -- requirements
Module: tt_sweep_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4, range 1..255: cycles dut_in is held before dut_out is sampled.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on clk.
REQ-005 start  input  1  single-cycle pulse; begins a sweep when idle.
REQ-006 abort  input  1  single-cycle pulse; terminates a running sweep.
REQ-007 cfg_we  input  1  expected-table write enable.
REQ-008 cfg_addr  input  4  expected-table index (input combination).
REQ-009 cfg_data  input  4  expected 4-bit output for cfg_addr.
REQ-010 dut_in  output  4  input combination driven to the 4-in/4-out logic block.
REQ-011 dut_out  input  4  logic block response.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 res_valid  output  1  one-cycle pulse per captured vector.
REQ-014 res_idx  output  4  index of the captured vector.
REQ-015 res_data  output  4  captured dut_out.
REQ-016 res_err  output  1  captured dut_out differs from the expected entry.
REQ-017 done  output  1  one-cycle pulse when a sweep completes all 16 vectors.
REQ-018 aborted  output  1  one-cycle pulse when a sweep is aborted.
REQ-019 pass  output  1  valid when done is high; high when err_count==0.
REQ-020 err_count  output  5  mismatch count, 0..16, held until the next start.
REQ-021 first_err_idx  output  4  index of the first mismatch; 0 if there was none.

Function
REQ-022 FSM states SHALL be IDLE, APPLY, SETTLE, CAPTURE, DONE.
REQ-023 IDLE: start=1 -> APPLY. Same edge: idx=0, err_count=0, first_err_idx=0.
REQ-024 APPLY (1 cycle): dut_in=idx; settle counter loaded with SETTLE_CYCLES-1; -> SETTLE.
REQ-025 SETTLE: counter decrements each cycle; counter==0 -> CAPTURE. Total SETTLE time is exactly SETTLE_CYCLES cycles.
REQ-026 CAPTURE (1 cycle): register dut_out into res_data and idx into res_idx; res_err = (dut_out != table[idx]); res_valid pulses on the following cycle.
REQ-027 CAPTURE mismatch: err_count increments by 1, saturating at 16. The first mismatch of a sweep loads first_err_idx.
REQ-028 CAPTURE exit: idx==15 -> DONE; otherwise idx+1 -> APPLY. idx never wraps within a sweep.
REQ-029 DONE (1 cycle): done=1; pass=(err_count==0); -> IDLE.
REQ-030 Per-vector period SHALL be SETTLE_CYCLES+2 cycles. done SHALL assert 16*(SETTLE_CYCLES+2)+1 cycles after the edge on which start is sampled.
REQ-031 dut_in SHALL remain stable from APPLY through CAPTURE of each vector. dut_in SHALL return to 0 in IDLE.
REQ-032 abort in any non-IDLE state -> IDLE on the next edge; aborted pulses; done does not assert; err_count is kept. abort in IDLE is ignored.
REQ-033 start while busy SHALL be ignored. If start and abort arrive together in a non-IDLE state, abort wins.
REQ-034 cfg_we SHALL write the table only in IDLE; writes while busy are dropped.
REQ-035 A table write and start on the same IDLE cycle: the write completes first, and the sweep uses the new value.
REQ-036 dut_out SHALL be treated as asynchronous to the sweep; it is sampled only in CAPTURE.

Reset
REQ-037 rst_n=0 SHALL force: state IDLE; dut_in=0; busy, res_valid, res_err, done, aborted, pass = 0; res_idx, res_data, err_count, first_err_idx = 0; all expected-table entries = 0.
REQ-038 Reset mid-sweep SHALL abandon the sweep with no done or aborted pulse.

Structure
REQ-039 Shared package tt_sweep_pkg SHALL hold the state enum, N_IN=4, N_OUT=4, N_VEC=16 and the err_count width.
REQ-040 One sub-module, tt_expect_table: a 16x4 register file with synchronous write, combinational read and synchronous reset.

Verification
REQ-041 Table[i]=~i, model dut_out=~dut_in, S=4, start -> 16 res_valid pulses with res_err=0; done at cycle 97; pass=1; err_count=0.
REQ-042 Same setup with table[5]=4'h0 -> only idx 5 has res_err=1; err_count=1; first_err_idx=5; pass=0.
REQ-043 Model dut_out=4'h0, table[i]=~i -> 15 mismatches (idx 15 matches); err_count=15; first_err_idx=0.
REQ-044 abort during SETTLE of idx 7 -> next cycle IDLE, aborted=1, dut_in=0, no done; start again -> full sweep.
REQ-045 start and cfg_we during busy -> both ignored; table unchanged; sweep timing unchanged.
REQ-046 rst_n=0 for one cycle at idx 10 -> all outputs 0 and table cleared on the next cycle; no done pulse.
